riscv_core_div: RTL and testbench

RISCV_CORE_DIV -- requirements
Module: riscv_core_div

---
 rtl/riscv_core_div_if.sv | 22 ++
 rtl/riscv_core_div.sv | 105 ++++++++++
 tb/tb_riscv_core_div.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/riscv_core_div_if.sv
// riscv_core_div_if: request/response bundle between the integer pipeline and the divider.
interface riscv_core_div_if #(parameter int XLEN = 64);
    logic [XLEN-1:0] i_div_srcA;
    logic [XLEN-1:0] i_div_srcB;
    logic [1:0]      i_div_control;
    logic            i_div_isword;
    logic            i_div_valid;
    logic            i_div_kill;
    logic            o_div_ready;
    logic            o_div_valid;
    logic [XLEN-1:0] o_div_result;

    modport master (
        output i_div_srcA, i_div_srcB, i_div_control, i_div_isword, i_div_valid, i_div_kill,
        input  o_div_ready, o_div_valid, o_div_result
    );

    modport slave (
        input  i_div_srcA, i_div_srcB, i_div_control, i_div_isword, i_div_valid, i_div_kill,
        output o_div_ready, o_div_valid, o_div_result
    );
endinterface

// File: rtl/riscv_core_div.sv
// riscv_core_div: iterative restoring divider for DIV/DIVU/REM/REMU and their W forms,
// one quotient bit per cycle, with zero-divisor and signed-overflow results resolved at accept.
module riscv_core_div #(parameter int XLEN = 64) (
    input logic              i_clk,
    input logic              i_rst,
    riscv_core_div_if.slave  div
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          r_state, w_state_nx;
    logic            r_valid, w_valid_nx, w_load, w_step;
    logic [XLEN-1:0] r_result;
    logic [6:0]      r_cnt;
    logic [XLEN-1:0] r_rem, r_quo, r_b;
    logic            r_rem_sel, r_w, r_neg_q, r_neg_a;

    logic            w_signed, w_neg_a, w_neg_b, w_zero, w_ovf, w_special, w_ge;
    logic [XLEN-1:0] w_a, w_b, w_mag_a, w_mag_b, w_spec_res, w_rem_nx, w_quo_nx, w_calc_res;
    logic [XLEN:0]   w_sh;

    function automatic logic [XLEN-1:0] f_res(input logic rem_sel, input logic w,
                                               input logic [XLEN-1:0] q, input logic [XLEN-1:0] r);
        logic [XLEN-1:0] s;
        s = rem_sel ? r : q;
        return w ? {{(XLEN-32){s[31]}}, s[31:0]} : s;
    endfunction

    assign w_signed   = ~div.i_div_control[0];
    assign w_a        = div.i_div_isword ? {{(XLEN-32){w_signed & div.i_div_srcA[31]}}, div.i_div_srcA[31:0]} : div.i_div_srcA;
    assign w_b        = div.i_div_isword ? {{(XLEN-32){w_signed & div.i_div_srcB[31]}}, div.i_div_srcB[31:0]} : div.i_div_srcB;
    assign w_neg_a    = w_signed & w_a[XLEN-1];
    assign w_neg_b    = w_signed & w_b[XLEN-1];
    assign w_mag_a    = w_neg_a ? -w_a : w_a;
    assign w_mag_b    = w_neg_b ? -w_b : w_b;
    assign w_zero     = w_b == '0;
    // The sign-extended W dividend makes the most-negative test width independent after masking.
    assign w_ovf      = w_signed & (w_b == '1) & (w_a == (div.i_div_isword ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}}));
    assign w_special  = w_zero | w_ovf;
    assign w_spec_res = f_res(div.i_div_control[1], div.i_div_isword, w_zero ? '1 : w_a, w_zero ? w_a : '0);

    assign w_sh       = {r_rem, r_quo[XLEN-1]};
    assign w_ge       = w_sh >= {1'b0, r_b};
    assign w_rem_nx   = w_ge ? w_sh[XLEN-1:0] - r_b : w_sh[XLEN-1:0];
    assign w_quo_nx   = {r_quo[XLEN-2:0], w_ge};
    assign w_calc_res = f_res(r_rem_sel, r_w, r_neg_q ? -w_quo_nx : w_quo_nx, r_neg_a ? -w_rem_nx : w_rem_nx);

    assign div.o_div_ready  = r_state == IDLE;
    assign div.o_div_valid  = r_valid;
    assign div.o_div_result = r_result;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_valid_nx = 1'b0;
        w_load     = 1'b0;
        w_step     = 1'b0;
        case (r_state)
            IDLE: begin
                w_load     = div.i_div_valid & ~div.i_div_kill;
                w_valid_nx = w_load & w_special;
                w_state_nx = w_load ? (w_special ? DONE : CALC) : IDLE;
            end
            CALC: begin
                w_step     = ~div.i_div_kill;
                w_valid_nx = w_step & (r_cnt == 7'd1);
                w_state_nx = div.i_div_kill ? IDLE : (r_cnt == 7'd1 ? DONE : CALC);
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_cnt    <= '0;
        end else begin
            r_valid <= w_valid_nx;
            if (w_load)              r_cnt    <= div.i_div_isword ? 7'd32 : 7'd64;
            if (w_step)              r_cnt    <= r_cnt - 7'd1;
            if (w_load & w_special)  r_result <= w_spec_res;
            if (w_step & w_valid_nx) r_result <= w_calc_res;
        end
    end

    // W dividends are pre-shifted to the top so 32 iterations consume exactly their bits.
    always_ff @(posedge i_clk) begin
        if (w_load) begin
            r_rem     <= '0;
            r_quo     <= div.i_div_isword ? {w_mag_a[31:0], {(XLEN-32){1'b0}}} : w_mag_a;
            r_b       <= w_mag_b;
            r_rem_sel <= div.i_div_control[1];
            r_w       <= div.i_div_isword;
            r_neg_q   <= w_neg_a ^ w_neg_b;
            r_neg_a   <= w_neg_a;
        end else if (w_step) begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
        end
    end
endmodule

// File: tb/tb_riscv_core_div.sv
// tb_riscv_core_div: directed vector table plus kill, reset and DONE-hold sequences.
module tb_riscv_core_div;
    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [1:0]  c;
        logic        w;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    logic i_clk, i_rst;
    int   n_cmp, n_err, n_pulse;
    vec_t vecs[20];

    riscv_core_div_if #(.XLEN(64)) dif();
    riscv_core_div #(.XLEN(64)) dut (.i_clk(i_clk), .i_rst(i_rst), .div(dif));

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) if (dif.o_div_valid === 1'b1) n_pulse++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic run_op(input string name, input logic [63:0] a, input logic [63:0] b,
                          input logic [1:0] c, input logic w, input logic [63:0] exp, input int lat);
        int k;
        dif.i_div_srcA    = a;
        dif.i_div_srcB    = b;
        dif.i_div_control = c;
        dif.i_div_isword  = w;
        dif.i_div_valid   = 1'b1;
        @(posedge i_clk);
        #1;
        dif.i_div_valid   = 1'b0;
        dif.i_div_srcA    = {$urandom, $urandom};
        dif.i_div_srcB    = {$urandom, $urandom};
        dif.i_div_control = 2'($urandom_range(0, 3));
        dif.i_div_isword  = 1'($urandom_range(0, 1));
        k = 1;
        while (dif.o_div_valid !== 1'b1 && k < 200) begin
            @(posedge i_clk);
            #1;
            k++;
        end
        chk({name, " latency"}, 64'(k), 64'(lat));
        chk({name, " result"}, dif.o_div_result, exp);
        @(posedge i_clk);
        #1;
        chk({name, " valid drop"}, 64'(dif.o_div_valid), 64'd0);
        chk({name, " ready back"}, 64'(dif.o_div_ready), 64'd1);
        chk({name, " result hold"}, dif.o_div_result, exp);
    endtask

    initial begin
        vecs[0]  = '{64'hFFFFFFFFFFFFFFF9, 64'd2, 2'b00, 1'b0, 64'hFFFFFFFFFFFFFFFD, 65};
        vecs[1]  = '{64'hFFFFFFFFFFFFFFF9, 64'd2, 2'b10, 1'b0, 64'hFFFFFFFFFFFFFFFF, 65};
        vecs[2]  = '{64'hDEAD0000FFFFFFFF, 64'h0000000100000002, 2'b01, 1'b1, 64'h000000007FFFFFFF, 33};
        vecs[3]  = '{64'd5, 64'd0, 2'b01, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1};
        vecs[4]  = '{64'd5, 64'd0, 2'b11, 1'b0, 64'h0000000000000005, 1};
        vecs[5]  = '{64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 2'b00, 1'b0, 64'h8000000000000000, 1};
        vecs[6]  = '{64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 2'b10, 1'b0, 64'h0, 1};
        vecs[7]  = '{64'h0000000080000000, 64'h00000000FFFFFFFF, 2'b00, 1'b1, 64'hFFFFFFFF80000000, 1};
        vecs[8]  = '{64'd100, 64'd7, 2'b01, 1'b0, 64'd14, 65};
        vecs[9]  = '{64'h00000000FFFFFFF9, 64'd2, 2'b10, 1'b1, 64'hFFFFFFFFFFFFFFFF, 33};
        vecs[10] = '{64'd7, 64'hFFFFFFFFFFFFFFFE, 2'b00, 1'b0, 64'hFFFFFFFFFFFFFFFD, 65};
        vecs[11] = '{64'd7, 64'hFFFFFFFFFFFFFFFE, 2'b10, 1'b0, 64'd1, 65};
        vecs[12] = '{64'hFFFFFFFFFFFFFFFF, 64'd1, 2'b01, 1'b0, 64'hFFFFFFFFFFFFFFFF, 65};
        vecs[13] = '{64'h00000000FFFFFFFF, 64'd1, 2'b01, 1'b1, 64'hFFFFFFFFFFFFFFFF, 33};
        vecs[14] = '{64'h0000000080000005, 64'h10, 2'b11, 1'b1, 64'd5, 33};
        vecs[15] = '{64'h1234567887654321, 64'hFFFFFFFF00000000, 2'b10, 1'b1, 64'hFFFFFFFF87654321, 1};
        vecs[16] = '{64'h7FFFFFFFFFFFFFFF, 64'h10, 2'b00, 1'b0, 64'h07FFFFFFFFFFFFFF, 65};
        vecs[17] = '{64'h00000000FFFFFF9C, 64'd7, 2'b00, 1'b1, 64'hFFFFFFFFFFFFFFF2, 33};
        vecs[18] = '{64'hABCDEF0000000064, 64'h00000000FFFFFFF9, 2'b00, 1'b1, 64'hFFFFFFFFFFFFFFF2, 33};
        vecs[19] = '{64'h0000000080000000, 64'h00000000FFFFFFFF, 2'b10, 1'b1, 64'h0, 1};

        n_cmp = 0;
        n_err = 0;
        n_pulse = 0;
        i_rst = 1'b1;
        dif.i_div_srcA = '0;
        dif.i_div_srcB = '0;
        dif.i_div_control = 2'b00;
        dif.i_div_isword = 1'b0;
        dif.i_div_valid = 1'b0;
        dif.i_div_kill = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("reset valid", 64'(dif.o_div_valid), 64'd0);
        chk("reset result", dif.o_div_result, 64'd0);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        chk("post-reset ready", 64'(dif.o_div_ready), 64'd1);

        for (int i = 0; i < 20; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].w, vecs[i].exp, vecs[i].lat);

        // kill at T+10 of a 64-bit division
        dif.i_div_srcA = 64'hFFFF0000FFFF0000;
        dif.i_div_srcB = 64'd3;
        dif.i_div_control = 2'b01;
        dif.i_div_isword = 1'b0;
        dif.i_div_valid = 1'b1;
        @(posedge i_clk);
        #1;
        dif.i_div_valid = 1'b0;
        chk("kill busy", 64'(dif.o_div_ready), 64'd0);
        repeat (8) @(posedge i_clk);
        #1;
        dif.i_div_kill = 1'b1;
        @(posedge i_clk);
        #1;
        dif.i_div_kill = 1'b0;
        chk("kill ready", 64'(dif.o_div_ready), 64'd1);
        chk("kill valid", 64'(dif.o_div_valid), 64'd0);
        begin
            int p0;
            p0 = n_pulse;
            repeat (70) @(posedge i_clk);
            #1;
            chk("kill no pulse", 64'(n_pulse), 64'(p0));
        end
        run_op("after kill", 64'd100, 64'd7, 2'b01, 1'b0, 64'd14, 65);

        // kill beats a simultaneous request in IDLE
        dif.i_div_srcA = 64'd100;
        dif.i_div_srcB = 64'd7;
        dif.i_div_valid = 1'b1;
        dif.i_div_kill = 1'b1;
        @(posedge i_clk);
        #1;
        dif.i_div_valid = 1'b0;
        dif.i_div_kill = 1'b0;
        chk("kill+valid ready", 64'(dif.o_div_ready), 64'd1);
        begin
            int p0;
            p0 = n_pulse;
            repeat (70) @(posedge i_clk);
            #1;
            chk("kill+valid no pulse", 64'(n_pulse), 64'(p0));
        end

        // reset at T+20 of a CALC, with a nonzero result still held
        dif.i_div_srcA = 64'd1000;
        dif.i_div_srcB = 64'd9;
        dif.i_div_control = 2'b01;
        dif.i_div_valid = 1'b1;
        @(posedge i_clk);
        #1;
        dif.i_div_valid = 1'b0;
        repeat (18) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        dif.i_div_kill = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        dif.i_div_kill = 1'b0;
        chk("mid reset valid", 64'(dif.o_div_valid), 64'd0);
        chk("mid reset result", dif.o_div_result, 64'd0);
        chk("mid reset ready", 64'(dif.o_div_ready), 64'd1);
        run_op("after reset", 64'd100, 64'd7, 2'b11, 1'b0, 64'd2, 65);

        // request held high through DONE must wait for IDLE
        dif.i_div_srcA = 64'd5;
        dif.i_div_srcB = 64'd0;
        dif.i_div_control = 2'b11;
        dif.i_div_isword = 1'b0;
        dif.i_div_valid = 1'b1;
        @(posedge i_clk);
        #1;
        chk("hold first pulse", 64'(dif.o_div_valid), 64'd1);
        chk("hold done not ready", 64'(dif.o_div_ready), 64'd0);
        @(posedge i_clk);
        #1;
        chk("hold no accept in done", 64'(dif.o_div_valid), 64'd0);
        chk("hold idle ready", 64'(dif.o_div_ready), 64'd1);
        @(posedge i_clk);
        #1;
        dif.i_div_valid = 1'b0;
        chk("hold second pulse", 64'(dif.o_div_valid), 64'd1);
        chk("hold second result", dif.o_div_result, 64'd5);
        @(posedge i_clk);
        #1;
        chk("hold end ready", 64'(dif.o_div_ready), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
